rx_ltssm: RTL

Receive-side LTSSM companion to the TX LTSSM. It sits between the RX ordered-set decoder and the main LTSSM. Per state commanded by the main LTSSM, it counts consecutive qualifying received TS1/TS2/IDLE ordered sets and reports the RX-side exit condition. It also captures the link number on upstream devices and times out stalled Polling/Configuration states.

---
 rtl/rx_ltssm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rx_ltssm.sv
// Receive-side LTSSM companion: counts consecutive qualifying TS1/TS2/IDLE ordered sets
// for the state commanded by the main LTSSM and reports the RX exit condition or a timeout.
module rx_ltssm #(
    parameter bit         DEVICETYPE     = 1'b0,
    parameter int         TIMEOUT_CYCLES = 24000,
    parameter logic [7:0] PAD            = 8'hF7
) (
    input  logic       Pclk,
    input  logic       Reset,
    input  logic [3:0] SetRXState,
    output logic       RXFinishFlag,
    output logic [3:0] RXExitTo,
    input  logic       OSValid,
    input  logic [1:0] OSType,
    input  logic [7:0] OSLinkNum,
    input  logic [7:0] OSLaneNum,
    input  logic [7:0] ReadLinkNum,
    output logic [7:0] WriteLinkNum,
    output logic       WriteLinkNumFlag,
    output logic       LinkUp
);

    typedef enum logic [3:0] {
        DETECT_QUIET        = 4'h0,
        DETECT_ACTIVE       = 4'h1,
        POLLING_ACTIVE      = 4'h2,
        POLLING_CONFIG      = 4'h3,
        CFG_LW_START        = 4'h4,
        CFG_LW_ACCEPT       = 4'h5,
        CFG_LANE_NUM_WAIT   = 4'h6,
        CFG_LANE_NUM_ACTIVE = 4'h7,
        CFG_COMPLETE        = 4'h8,
        CFG_IDLE            = 4'h9,
        L0                  = 4'hA,
        IDLE                = 4'hF
    } state_t;

    typedef enum logic [1:0] {
        OS_TS1   = 2'b00,
        OS_TS2   = 2'b01,
        OS_IDLE  = 2'b10,
        OS_OTHER = 2'b11
    } os_type_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [4:0] COUNT_MAX = 5'd16;

    state_t          state;
    logic [4:0]      count;
    logic [TW-1:0]   timer;
    logic            done;

    logic            counting;
    logic            qualifies;
    logic [4:0]      target;
    state_t          exit_to;
    logic            link_pad;
    logic            lane_pad;
    logic            link_ok;
    logic            is_ts1;
    logic            is_ts2;
    logic [4:0]      count_inc;
    logic            entry;
    logic            hit;
    logic            timer_active;
    logic            timeout;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        counting  = 1'b1;
        qualifies = 1'b0;
        target    = 5'd2;
        exit_to   = DETECT_QUIET;
        link_pad  = (OSLinkNum == PAD);
        lane_pad  = (OSLaneNum == PAD);
        link_ok   = (OSLinkNum == ReadLinkNum);
        is_ts1    = (os_type_t'(OSType) == OS_TS1);
        is_ts2    = (os_type_t'(OSType) == OS_TS2);
        case (state)
            POLLING_ACTIVE: begin
                qualifies = (is_ts1 || is_ts2) && link_pad && lane_pad;
                target    = 5'd8;
                exit_to   = POLLING_CONFIG;
            end
            POLLING_CONFIG: begin
                qualifies = is_ts2 && link_pad && lane_pad;
                target    = 5'd8;
                exit_to   = CFG_LW_START;
            end
            CFG_LW_START: begin
                // Upstream ports learn the link number; downstream ports check their own.
                qualifies = DEVICETYPE ? (is_ts1 && !link_pad && lane_pad) : (is_ts1 && link_ok);
                exit_to   = CFG_LW_ACCEPT;
            end
            CFG_LW_ACCEPT: begin
                qualifies = is_ts1 && link_ok && !lane_pad;
                exit_to   = CFG_LANE_NUM_WAIT;
            end
            CFG_LANE_NUM_WAIT: begin
                qualifies = is_ts1 && link_ok && !lane_pad;
                exit_to   = CFG_LANE_NUM_ACTIVE;
            end
            CFG_LANE_NUM_ACTIVE: begin
                qualifies = is_ts1 && link_ok && !lane_pad;
                exit_to   = CFG_COMPLETE;
            end
            CFG_COMPLETE: begin
                qualifies = is_ts2 && link_ok && !lane_pad;
                target    = 5'd8;
                exit_to   = CFG_IDLE;
            end
            CFG_IDLE: begin
                qualifies = (os_type_t'(OSType) == OS_IDLE);
                target    = 5'd8;
                exit_to   = L0;
            end
            default: counting = 1'b0;
        endcase
    end

    assign count_inc    = (count >= COUNT_MAX) ? COUNT_MAX : count + 5'd1;
    assign entry        = (SetRXState != state);
    assign hit          = counting && OSValid && qualifies && !done && (count_inc >= target);
    assign timer_active = (state >= POLLING_ACTIVE) && (state <= CFG_IDLE) && !done;
    assign timeout      = timer_active && (timer == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments only, and the reset is synchronous.
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            state            <= IDLE;
            count            <= '0;
            timer            <= '0;
            done             <= 1'b0;
            RXFinishFlag     <= 1'b0;
            RXExitTo         <= 4'h0;
            WriteLinkNum     <= 8'h00;
            WriteLinkNumFlag <= 1'b0;
            LinkUp           <= 1'b0;
        end else begin
            state            <= state_t'(SetRXState);
            RXFinishFlag     <= 1'b0;
            WriteLinkNumFlag <= 1'b0;
            if (entry) begin
                // A state change wins over any match seen in the same cycle.
                count <= '0;
                timer <= '0;
                done  <= 1'b0;
                if (state_t'(SetRXState) != L0)
                    LinkUp <= 1'b0;
            end else begin
                if (OSValid && counting)
                    count <= qualifies ? count_inc : 5'd0;
                if (timer_active)
                    timer <= timer + 1'b1;
                if (hit) begin
                    RXFinishFlag <= 1'b1;
                    RXExitTo     <= exit_to;
                    done         <= 1'b1;
                    if (DEVICETYPE && state == CFG_LW_START) begin
                        WriteLinkNum     <= OSLinkNum;
                        WriteLinkNumFlag <= 1'b1;
                    end
                    if (state == CFG_IDLE)
                        LinkUp <= 1'b1;
                end else if (timeout) begin
                    RXFinishFlag <= 1'b1;
                    RXExitTo     <= DETECT_QUIET;
                    done         <= 1'b1;
                end
            end
        end
    end

endmodule
